axi_sram_slave: RTL and testbench
=================================

# axi_sram_slave

AXI3 slave backed by an internal word-organised SRAM; the responder end of the CPU's AXI master port. It answers read (AR/R) and write (AW/W/B) transactions with single-beat or INCR/FIXED bursts of up to 16 beats. It is used as the instruction/data memory in SoC and simulation builds. It serves one transaction at a time.

## Interface
- ADDR_BITS, 14: word-address width; memory is 2^ADDR_BITS 32-bit words (64 KiB at the default).
- READ_LAT, 1: idle cycles between AR handshake and first rvalid (0–7).
- aclk  in  1  clock; all state is updated on the rising edge.
- aresetn  in  1  reset, asynchronous assert, active-low.
- arid/araddr/arlen/arsize/arburst  in  4/32/4/3/2  read address; arlock/arcache/arprot inputs are accepted and ignored.
- arvalid in 1, arready out 1  read address handshake.
- rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1  read data channel; rready in 1.
- awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2  write address; only awlen[3:0] is used; awlock/awcache/awprot are ignored.
- awvalid in 1, awready out 1  write address handshake.
- wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1  write data; wready out 1.
- bid/bresp/bvalid  out  4/2/1  write response; bready in 1.

## Operation
- FSM states:
  - IDLE → WR_DATA on an AW handshake.
  - IDLE → RD_WAIT on an AR handshake, or directly to RD_DATA when READ_LAT = 0.
  - RD_WAIT → RD_DATA when the latency counter reaches READ_LAT.
  - RD_DATA → IDLE on the final R handshake.
  - WR_DATA → WR_RESP on the final W handshake.
  - WR_RESP → IDLE on the B handshake.
- Handshakes in IDLE:
  - awready = 1 in IDLE.
  - arready = IDLE & ~awvalid, so writes win when AW and AR arrive in the same cycle.
  - All ready signals are 0 outside IDLE.
- On address accept, the block latches the id, address, len and burst type; the beat counter is cleared.
- Word index = addr[ADDR_BITS+1:2]. Address bits [1:0] and the size field never alter data placement: rdata is always the full word, and byte lanes are selected only by wstrb.
- Address advance per beat:
  - arburst/awburst 2'b00 (FIXED): the address holds.
  - Any other encoding is treated as INCR: the word index increments by 1 and wraps modulo 2^ADDR_BITS.
- Read: in RD_DATA, rvalid = 1, rdata = mem[index], and rid = the latched id. rlast = (beat == len). rvalid and all payload signals hold stable until rready.
- Write: in WR_DATA, wready = 1. On each W handshake, byte lane i of mem[index] is written iff wstrb[i].
  - The burst ends when beat == len; wlast and wid are ignored.
- Response: bvalid = 1 and bid = the latched awid in WR_RESP, held until bready.
- rresp and bresp are 2'b00 unless AXI_SLAVE_ERR_RESP_EN is defined.
- Reset values: arready, awready, wready, rvalid, rlast and bvalid = 0; rdata = 0; rid and bid = 0; rresp and bresp = 0; FSM in IDLE. Memory contents are not reset.
- Reset mid-transaction: the FSM returns to IDLE immediately. Beats already written stay committed, and no response is issued.

## Timing
- AR handshake in cycle T → first rvalid in cycle T+1+READ_LAT. With rready held high, beats are back-to-back, one per cycle.
- AW handshake in cycle T → wready = 1 from T+1. Each beat commits on its W handshake edge; bvalid rises the cycle after the final W handshake.
- After the final R or B handshake, the FSM is in IDLE the next cycle. The earliest next address accept is therefore one cycle after completion; there are no overlapping transactions.
- Read-after-write to the same word returns the new data, because the B handshake precedes the next AR accept.
- Back-pressure: when rready or bready is low, state and outputs are frozen indefinitely.

## Configuration
- AXI_SLAVE_ERR_RESP_EN defined:
  - An address with any of addr[31:ADDR_BITS+2] nonzero is out of range.
  - Out-of-range read beats return rdata = 0 and rresp = 2'b10 (SLVERR).
  - Out-of-range write bursts update no memory and return bresp = 2'b10.
  - The range check uses the start address latched at accept.
- Undefined: the upper address bits are ignored (aliasing, e.g. 0xBFC00000 maps to word 0), and all responses are OKAY.

## Test plan
- Write 0x12345678 to 0x00000010 with wstrb = 4'hF, then read 0x10 → bresp = 0; rdata = 0x12345678 with rlast = 1, arriving READ_LAT+1 cycles after the AR handshake.
- Partial write: wstrb = 4'b0010 with wdata = 0x0000AB00 over that word → a read returns 0x1234AB78.
- INCR burst: awlen = 3 writes 0xA0..0xA3 starting at 0x100, then arlen = 3 reads them back → four back-to-back beats with rlast only on the 4th; a FIXED read of len 1 at 0x100 returns 0xA0 twice.
- awvalid and arvalid asserted in the same cycle → awready = 1, arready = 0; the read is accepted only after bvalid & bready, and it returns the written data.
- rready held low for 5 cycles mid-burst → rdata, rlast and rvalid are unchanged throughout; aresetn pulsed during WR_DATA → all valid/ready outputs are 0 and arready = 1 in the cycle after release.
- With AXI_SLAVE_ERR_RESP_EN defined, read 0x80000000 (ADDR_BITS = 14) → rresp = 2'b10, rdata = 0; without the macro, the same read returns mem[0] with rresp = 0.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI3 slave over a word-organised SRAM, one transaction at a time, INCR/FIXED bursts up to 16 beats.
// Optional macro AXI_SLAVE_ERR_RESP_EN: out-of-range accesses return SLVERR and writes are dropped.
module axi_sram_slave #(
    parameter int ADDR_BITS = 14,
    parameter int READ_LAT  = 1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP} state_t;

    localparam int MEM_WORDS = 1 << ADDR_BITS;

    logic [31:0] mem [MEM_WORDS];

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] idx_q, idx_d, idx_nxt;
    logic [3:0]           len_q, len_d;
    logic [3:0]           beat_q, beat_d;
    logic [3:0]           id_q, id_d;
    logic                 fixed_q, fixed_d;
    logic                 err_q, err_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 ar_err, aw_err;
    logic                 mem_we;
    logic                 unused_sig;

`ifdef AXI_SLAVE_ERR_RESP_EN
    assign ar_err = (araddr >> (ADDR_BITS + 2)) != 32'd0;
    assign aw_err = (awaddr >> (ADDR_BITS + 2)) != 32'd0;
`else
    assign ar_err = 1'b0;
    assign aw_err = 1'b0;
`endif

    assign unused_sig = ^{arsize, arlock, arcache, arprot, awsize, awlock, awcache, awprot,
                          awlen[7:4], wid, wlast, araddr[1:0], awaddr[1:0],
                          araddr[31:ADDR_BITS+2], awaddr[31:ADDR_BITS+2]};

    // Out-of-range beats read as zero so no aliased data leaks out.
    function automatic logic [31:0] rd_word(input logic [ADDR_BITS-1:0] i, input logic e);
        return e ? 32'd0 : mem[i];
    endfunction

    assign idx_nxt = fixed_q ? idx_q : idx_q + ADDR_BITS'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        beat_d  = beat_q;
        id_d    = id_q;
        fixed_d = fixed_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (awvalid) begin
                    state_d = WR_DATA;
                    id_d    = awid;
                    idx_d   = awaddr[ADDR_BITS+1:2];
                    len_d   = awlen[3:0];
                    fixed_d = (awburst == 2'b00);
                    err_d   = aw_err;
                    beat_d  = 4'd0;
                end else if (arvalid) begin
                    state_d = (READ_LAT == 0) ? RD_DATA : RD_WAIT;
                    id_d    = arid;
                    idx_d   = araddr[ADDR_BITS+1:2];
                    len_d   = arlen;
                    fixed_d = (arburst == 2'b00);
                    err_d   = ar_err;
                    beat_d  = 4'd0;
                    cnt_d   = 3'd0;
                    // Memory cannot change during a read, so the first word is fetched at accept.
                    rdata_d = rd_word(araddr[ADDR_BITS+1:2], ar_err);
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q + 3'd1;
                if ({1'b0, cnt_q} + 4'd1 == 4'(READ_LAT)) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (rready) begin
                    if (beat_q == len_q) begin
                        state_d = IDLE;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                        idx_d   = idx_nxt;
                        rdata_d = rd_word(idx_nxt, err_q);
                    end
                end
            end
            WR_DATA: begin
                if (wvalid) begin
                    mem_we = !err_q;
                    if (beat_q == len_q) begin
                        state_d = WR_RESP;
                    end else begin
                        beat_d = beat_q + 4'd1;
                        idx_d  = idx_nxt;
                    end
                end
            end
            WR_RESP: begin
                if (bready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= 4'd0;
            beat_q  <= 4'd0;
            id_q    <= 4'd0;
            fixed_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 3'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            id_q    <= id_d;
            fixed_q <= fixed_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[idx_q][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Readiness is held low while reset is asserted even though the FSM sits in IDLE.
    assign awready = aresetn && (state_q == IDLE);
    assign arready = aresetn && (state_q == IDLE) && !awvalid;
    assign wready  = (state_q == WR_DATA);
    assign rvalid  = (state_q == RD_DATA);
    assign rlast   = rvalid && (beat_q == len_q);
    assign rdata   = rdata_q;
    assign rid     = id_q;
    assign rresp   = (rvalid && err_q) ? 2'b10 : 2'b00;
    assign bvalid  = (state_q == WR_RESP);
    assign bid     = id_q;
    assign bresp   = (bvalid && err_q) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with a word-array reference model and per-cycle R/B checking.
module tb_axi_sram_slave;

    localparam int AB = 14;
    localparam int RL = 1;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [3:0]  arlen = '0;
    logic [2:0]  arsize = 3'd2;
    logic [1:0]  arburst = 2'b01;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid;
    logic        rready = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = 3'd2;
    logic [1:0]  awburst = 2'b01;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    axi_sram_slave #(.ADDR_BITS(AB), .READ_LAT(RL)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(2'b00), .arcache(4'h0), .arprot(3'h0), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(2'b00), .awcache(4'h0), .awprot(3'h0), .awvalid(awvalid), .awready(awready),
        .wid(4'h0), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [3:0]  id;
        logic [1:0]  resp;
    } rexp_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [1 << AB];
    rexp_t       exp_r[$];
    bexp_t       exp_b[$];
    logic [31:0] got_q[$];
    logic [31:0] wd_q[$];
    logic [3:0]  ws_q[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic chk_got(input string nm, input logic [31:0] exp);
        if (got_q.size() == 0) begin
            chk({nm, "_missing"}, 32'd0, 32'd1);
        end else begin
            chk(nm, got_q.pop_front(), exp);
        end
    endtask

    function automatic logic addr_err(input logic [31:0] a);
`ifdef AXI_SLAVE_ERR_RESP_EN
        return a[31:AB+2] != '0;
`else
        return 1'b0;
`endif
    endfunction

    // Every cycle with a valid R or B beat is compared with the model's next expected beat.
    initial begin
        rexp_t e;
        bexp_t f;
        forever begin
            @(negedge aclk);
            #3;
            if (rvalid) begin
                if (exp_r.size() == 0) begin
                    chk("r_unexpected", {31'd0, rvalid}, 32'd0);
                end else begin
                    e = exp_r[0];
                    chk("rdata", rdata, e.data);
                    chk("rlast", {31'd0, rlast}, {31'd0, e.last});
                    chk("rid", {28'd0, rid}, {28'd0, e.id});
                    chk("rresp", {30'd0, rresp}, {30'd0, e.resp});
                    if (rready) begin
                        got_q.push_back(rdata);
                        void'(exp_r.pop_front());
                    end
                end
            end
            if (bvalid) begin
                if (exp_b.size() == 0) begin
                    chk("b_unexpected", {31'd0, bvalid}, 32'd0);
                end else begin
                    f = exp_b[0];
                    chk("bid", {28'd0, bid}, {28'd0, f.id});
                    chk("bresp", {30'd0, bresp}, {30'd0, f.resp});
                    if (bready) void'(exp_b.pop_front());
                end
            end
        end
    end

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id,
                            input logic [3:0] len, input logic [1:0] burst);
        int n;
        logic [AB-1:0] idx;
        logic e;
        bexp_t f;
        idx = addr[AB+1:2];
        e = addr_err(addr);
        @(negedge aclk);
        awvalid = 1'b1; awaddr = addr; awid = id; awlen = {4'h0, len}; awburst = burst;
        n = 0;
        while (1) begin
            #1;
            if (awready || n >= 50) break;
            @(negedge aclk);
            n++;
        end
        chk("aw_handshake", {31'd0, awready}, 32'd1);
        for (int b = 0; b <= int'(len); b++) begin
            @(negedge aclk);
            awvalid = 1'b0; wvalid = 1'b1; wdata = wd_q[b]; wstrb = ws_q[b]; wlast = (b == int'(len));
            #1;
            chk("w_ready", {31'd0, wready}, 32'd1);
            if (!e) begin
                for (int i = 0; i < 4; i++) begin
                    if (ws_q[b][i]) model[idx][8*i +: 8] = wd_q[b][8*i +: 8];
                end
            end
            if (burst != 2'b00) idx = idx + 1'b1;
        end
        @(negedge aclk);
        wvalid = 1'b0; wlast = 1'b0;
        #1;
        chk("b_rise", {31'd0, bvalid}, 32'd1);
        f.id = id;
        f.resp = e ? 2'b10 : 2'b00;
        exp_b.push_back(f);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        wd_q.delete();
        ws_q.delete();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                           input logic [1:0] burst, input int stall_at);
        int n, k, b;
        logic [AB-1:0] idx;
        logic e;
        rexp_t r;
        idx = addr[AB+1:2];
        e = addr_err(addr);
        for (int i = 0; i <= int'(len); i++) begin
            r.data = e ? 32'd0 : model[idx];
            r.last = (i == int'(len));
            r.id = id;
            r.resp = e ? 2'b10 : 2'b00;
            exp_r.push_back(r);
            if (burst != 2'b00) idx = idx + 1'b1;
        end
        @(negedge aclk);
        arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arburst = burst;
        n = 0;
        while (1) begin
            #1;
            if (arready || n >= 50) break;
            @(negedge aclk);
            n++;
        end
        chk("ar_handshake", {31'd0, arready}, 32'd1);
        @(negedge aclk);
        arvalid = 1'b0; rready = 1'b1;
        k = 1;
        while (1) begin
            #1;
            if (rvalid || k >= 20) break;
            @(negedge aclk);
            k++;
        end
        chk("r_latency", k, RL + 1);
        b = 0;
        while (b <= int'(len)) begin
            chk("r_back_to_back", {31'd0, rvalid}, 32'd1);
            b++;
            @(negedge aclk);
            if (b == stall_at && b <= int'(len)) begin
                rready = 1'b0;
                repeat (5) @(negedge aclk);
                rready = 1'b1;
            end
            #1;
        end
        rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        @(negedge aclk);
        #1;
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rlast", {31'd0, rlast}, 32'd0);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_ids", {24'd0, rid, bid}, 32'd0);
        chk("rst_resps", {28'd0, rresp, bresp}, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("post_rst_arready", {31'd0, arready}, 32'd1);
        chk("post_rst_awready", {31'd0, awready}, 32'd1);

        // Word 0 seed, then full-word write / read of 0x10
        wd_q = '{32'hCAFEF00D}; ws_q = '{4'hF};
        do_write(32'h0, 4'd1, 4'd0, 2'b01);
        wd_q = '{32'h12345678}; ws_q = '{4'hF};
        do_write(32'h10, 4'd2, 4'd0, 2'b01);
        do_read(32'h10, 4'd3, 4'd0, 2'b01, -1);
        chk_got("single_rd", 32'h12345678);

        // Partial write on byte lane 1
        wd_q = '{32'h0000AB00}; ws_q = '{4'b0010};
        do_write(32'h10, 4'd4, 4'd0, 2'b01);
        chk("model_partial", model[4], 32'h1234AB78);
        do_read(32'h10, 4'd5, 4'd0, 2'b01, -1);
        chk_got("partial_rd", 32'h1234AB78);

        // Upper address bits: aliasing by default, SLVERR with the error macro
        wd_q = '{32'hDEADBEEF}; ws_q = '{4'hF};
        do_write(32'h80000010, 4'd6, 4'd0, 2'b01);
        do_read(32'h10, 4'd7, 4'd0, 2'b01, -1);
`ifdef AXI_SLAVE_ERR_RESP_EN
        chk_got("oor_wr_dropped", 32'h1234AB78);
`else
        chk_got("alias_wr", 32'hDEADBEEF);
`endif
        do_read(32'h80000000, 4'd8, 4'd0, 2'b01, -1);
`ifdef AXI_SLAVE_ERR_RESP_EN
        chk_got("oor_rd", 32'h0);
`else
        chk_got("alias_rd", 32'hCAFEF00D);
`endif

        // INCR burst write then read with a 5-cycle stall on the third beat
        wd_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3}; ws_q = '{4'hF, 4'hF, 4'hF, 4'hF};
        do_write(32'h100, 4'd9, 4'd3, 2'b01);
        do_read(32'h100, 4'd10, 4'd3, 2'b01, 2);
        chk_got("incr_b0", 32'hA0);
        chk_got("incr_b1", 32'hA1);
        chk_got("incr_b2", 32'hA2);
        chk_got("incr_b3", 32'hA3);

        // FIXED read holds the address
        do_read(32'h100, 4'd11, 4'd1, 2'b00, -1);
        chk_got("fixed_b0", 32'hA0);
        chk_got("fixed_b1", 32'hA0);

        // INCR write crossing the top of memory wraps to word 0
        wd_q = '{32'h11111111, 32'h22222222}; ws_q = '{4'hF, 4'hF};
        do_write(32'h0000FFFC, 4'd12, 4'd1, 2'b01);
        do_read(32'h0, 4'd13, 4'd0, 2'b01, -1);
        chk_got("wrap_rd", 32'h22222222);

        // AW and AR in the same cycle: write first, read after B
        @(negedge aclk);
        awvalid = 1'b1; awaddr = 32'h20; awid = 4'd7; awlen = 8'd0; awburst = 2'b01;
        arvalid = 1'b1; araddr = 32'h20; arid = 4'd8; arlen = 4'd0; arburst = 2'b01;
        #1;
        chk("sim_awready", {31'd0, awready}, 32'd1);
        chk("sim_arready", {31'd0, arready}, 32'd0);
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b1; wdata = 32'h5A5A0F0F; wstrb = 4'hF; wlast = 1'b1;
        #1;
        chk("sim_wready", {31'd0, wready}, 32'd1);
        chk("sim_arready_wr", {31'd0, arready}, 32'd0);
        model[8] = 32'h5A5A0F0F;
        @(negedge aclk);
        wvalid = 1'b0; wlast = 1'b0;
        #1;
        chk("sim_bvalid", {31'd0, bvalid}, 32'd1);
        chk("sim_arready_resp", {31'd0, arready}, 32'd0);
        exp_b.push_back('{id: 4'd7, resp: 2'b00});
        exp_r.push_back('{data: model[8], last: 1'b1, id: 4'd8, resp: 2'b00});
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        #1;
        chk("sim_arready_after_b", {31'd0, arready}, 32'd1);
        @(negedge aclk);
        arvalid = 1'b0; rready = 1'b1;
        n = 0;
        while (1) begin
            #1;
            if (rvalid || n >= 20) break;
            @(negedge aclk);
            n++;
        end
        chk("sim_rvalid", {31'd0, rvalid}, 32'd1);
        @(negedge aclk);
        rready = 1'b0;
        #1;
        chk_got("sim_rd", 32'h5A5A0F0F);

        // Reset during WR_DATA after one committed beat
        @(negedge aclk);
        awvalid = 1'b1; awaddr = 32'h30; awid = 4'd9; awlen = 8'd3; awburst = 2'b01;
        #1;
        chk("mid_awready", {31'd0, awready}, 32'd1);
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b1; wdata = 32'h77777777; wstrb = 4'hF;
        #1;
        chk("mid_wready", {31'd0, wready}, 32'd1);
        model[12] = 32'h77777777;
        @(negedge aclk);
        wvalid = 1'b0; aresetn = 1'b0;
        #1;
        chk("mid_rst_rdy", {29'd0, arready, awready, wready}, 32'd0);
        chk("mid_rst_vld", {29'd0, rvalid, bvalid, rlast}, 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("mid_rel_arready", {31'd0, arready}, 32'd1);
        chk("mid_rel_wready", {31'd0, wready}, 32'd0);
        chk("mid_rel_bvalid", {31'd0, bvalid}, 32'd0);
        do_read(32'h30, 4'd14, 4'd0, 2'b01, -1);
        chk_got("mid_rst_committed", 32'h77777777);

        repeat (3) @(negedge aclk);
        chk("r_queue_drained", exp_r.size(), 32'd0);
        chk("b_queue_drained", exp_b.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
